// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit that owns HI/LO: radix-2 shift-add multiply, restoring divide, one bit per cycle.
// Define MULDIV_FAST_MUL_EN to compute products with a single-cycle multiplier instead of the iterative path.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mdOp,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_mul, neg_q, neg_r;
  logic [WIDTH-1:0]   opb;   // multiplicand (mult) or divisor magnitude (div)
  logic [2*WIDTH-1:0] acc;   // product accumulator; low half is the dividend/quotient shifter
  logic [WIDTH-1:0]   rem;

  logic               s1, s2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rmd;

  always_comb begin
    s1       = ~mdOp[0] & din1[WIDTH-1];
    s2       = ~mdOp[0] & din2[WIDTH-1];
    mag1     = s1 ? -din1 : din1;
    mag2     = s2 ? -din2 : din2;
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    div_sh   = {rem, acc[WIDTH-1]};
    div_diff = div_sh - {1'b0, opb};
    // remainder stays below the divisor, so a set top bit means the trial subtract went negative
    div_ge   = ~div_diff[WIDTH];
    prod     = neg_q ? -acc : acc;
    quo      = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rmd      = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      is_mul <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opb    <= '0;
      acc    <= '0;
      rem    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !cancel) begin
          busy   <= 1'b1;
          is_mul <= mdOp[1];
          opb    <= mdOp[1] ? mag1 : mag2;
          acc    <= {{WIDTH{1'b0}}, (mdOp[1] ? mag2 : mag1)};
          rem    <= '0;
          neg_q  <= s1 ^ s2;
          neg_r  <= s1;
          cnt    <= CNT_W'(WIDTH);
          state  <= RUN;
          // divide by zero: preload the architectural result and let FIX publish it unsigned
          if (!mdOp[1] && din2 == '0) begin
            state <= FIX;
            rem   <= din1;
            acc   <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
            neg_q <= 1'b0;
            neg_r <= 1'b0;
          end
`ifdef MULDIV_FAST_MUL_EN
          if (mdOp[1]) begin
            state <= FIX;
            acc   <= {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
          end
`endif
        end
        RUN: if (cancel) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
          if (is_mul) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end else begin
            rem              <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], div_ge};
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!cancel) begin
            done <= 1'b1;
            if (is_mul) begin
              hi <= prod[2*WIDTH-1:WIDTH];
              lo <= prod[WIDTH-1:0];
            end else begin
              hi <= rmd;
              lo <= quo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
